ahb_display_regs: RTL and testbench

AHB_DISPLAY_REGS -- requirements
Module: ahb_display_regs

---
 rtl/ahb_display_regs.sv | 96 +++++++++
 tb/tb_ahb_display_regs.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_display_regs.sv
// ahb_display_regs: AHB-Lite slave exposing hex display, LEDs, switches and
// pushbuttons with press flags, with a two-cycle ERROR response on bad accesses.
module ahb_display_regs #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    HSEL,
  input  logic [ADDRESSWIDTH-1:0] HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [DATAWIDTH-1:0]    HWDATA,
  input  logic                    HREADY,
  output logic [DATAWIDTH-1:0]    HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  input  logic [17:0]             sw,
  input  logic [3:0]              key,
  output logic [31:0]             display_data,
  output logic [17:0]             ledr,
  output logic [8:0]              ledg
);
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
  state_t      state;
  logic        dp_valid, dp_write;
  logic [2:0]  dp_idx, dp_size;
  logic [1:0]  dp_lo;
  logic [31:0] scratch, rdata, wmask, wdata;
  logic [17:0] sw_a, sw_b;
  logic [3:0]  key_a, key_b, flags, lanes, clr;
  logic [2:0]  idx;
  logic        acc, err, wr, unused;
  assign unused = ^{HADDR[ADDRESSWIDTH-1:5], HTRANS[0]};
  assign idx = HADDR[4:2];
  assign acc = HSEL & HREADY & HTRANS[1];
  assign err = (idx == 3'd7) | (HWRITE & (idx == 3'd3 | idx == 3'd4)) | (HSIZE > 3'd2) |
               (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & HADDR[1:0] != 2'd0);
  assign lanes = dp_size == 3'd0 ? 4'b0001 << dp_lo :
                 dp_size == 3'd1 ? (dp_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign wr = dp_valid & dp_write;
  // Merging into the current read value keeps unselected lanes intact
  assign wdata = (rdata & ~wmask) | (HWDATA & wmask);
  assign clr = (wr && dp_idx == 3'd5) ? HWDATA[3:0] & wmask[3:0] : 4'd0;
  always_comb
    case (dp_idx)
      3'd0:    rdata = display_data;
      3'd1:    rdata = {14'd0, ledr};
      3'd2:    rdata = {23'd0, ledg};
      3'd3:    rdata = {14'd0, sw_b};
      3'd4:    rdata = {24'd0, flags, key_b};
      3'd6:    rdata = scratch;
      default: rdata = '0;
    endcase
  assign HRDATA    = (dp_valid & ~dp_write) ? rdata : '0;
  assign HREADYOUT = state != ERR1;
  assign HRESP     = state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      dp_valid     <= 1'b0;
      dp_write     <= 1'b0;
      dp_idx       <= '0;
      dp_size      <= '0;
      dp_lo        <= '0;
      display_data <= '0;
      ledr         <= '0;
      ledg         <= '0;
      scratch      <= '0;
      sw_a         <= '0;
      sw_b         <= '0;
      key_a        <= '0;
      key_b        <= '0;
      flags        <= '0;
    end else begin
      sw_a  <= sw;
      sw_b  <= sw_a;
      key_a <= key;
      key_b <= key_a;
      flags <= (flags & ~clr) | (key_b & ~key_a);
      if (wr && dp_idx == 3'd0) display_data <= wdata;
      if (wr && dp_idx == 3'd1) ledr <= wdata[17:0];
      if (wr && dp_idx == 3'd2) ledg <= wdata[8:0];
      if (wr && dp_idx == 3'd6) scratch <= wdata;
      if (HREADY) begin
        dp_valid <= acc & ~err;
        dp_write <= HWRITE;
        dp_idx   <= idx;
        dp_size  <= HSIZE;
        dp_lo    <= HADDR[1:0];
      end
      state <= (acc & err) ? ERR1 : (state == ERR1) ? ERR2 : IDLE;
    end
endmodule

// File: tb/tb_ahb_display_regs.sv
// tb_ahb_display_regs: random AHB traffic against a word-array model of the
// register block, plus directed scenarios with literal expectations.
module tb_ahb_display_regs;
  logic        clk = 0, reset_n = 1, hsel = 0, hwrite = 0, hready = 1;
  logic [27:0] haddr = 0;
  logic [1:0]  htrans = 0;
  logic [2:0]  hsize = 0;
  logic [31:0] hwdata = 0, hrdata, display_data;
  logic [17:0] sw = 18'h2A5A5, ledr;
  logic [3:0]  key = 4'hF;
  logic [8:0]  ledg;
  logic        hreadyout, hresp;
  int          vecs = 0, errs = 0;

  always #5 clk = ~clk;

  ahb_display_regs dut (
    .clk(clk), .reset_n(reset_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp), .sw(sw), .key(key),
    .display_data(display_data), .ledr(ledr), .ledg(ledg));

  // Model: RW registers as a word array, synchronisers as 2-deep histories
  logic [31:0] mem [8];
  logic [3:0]  flg;
  logic [17:0] swq [2];
  logic [3:0]  kq [2];
  logic        p_v, p_w;
  logic [4:0]  p_a;
  logic [2:0]  p_s;
  int          eph;
  logic [31:0] exp_rdata;
  logic        exp_ready, exp_resp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] rd(input logic [2:0] i);
    case (i)
      3'd3:          return {14'd0, swq[1]};
      3'd4:          return {24'd0, flg, kq[1]};
      3'd5, 3'd7:    return 32'd0;
      default:       return mem[i];
    endcase
  endfunction

  task automatic mzero();
    foreach (mem[i]) mem[i] = 0;
    flg = 0; swq[0] = 0; swq[1] = 0; kq[0] = 0; kq[1] = 0;
    p_v = 0; p_w = 0; p_a = 0; p_s = 0; eph = 0;
  endtask

  task automatic mstep();
    logic [31:0] m;
    logic [3:0]  clr;
    logic        acc, bad;
    int          lo, n;
    logic [2:0]  i;
    clr = 0;
    if (p_v && p_w) begin
      lo = int'(p_a[1:0]);
      n  = 1 << p_s;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = (b >= lo && b < lo + n) ? 8'hFF : 8'h00;
      i = p_a[4:2];
      if (i == 0 || i == 1 || i == 2 || i == 6) mem[i] = (mem[i] & ~m) | (hwdata & m);
      if (i == 5) clr = hwdata[3:0] & m[3:0];
      mem[1] &= 32'h3FFFF;
      mem[2] &= 32'h1FF;
    end
    flg = (flg & ~clr) | (kq[1] & ~kq[0]);
    kq[1] = kq[0]; kq[0] = key;
    swq[1] = swq[0]; swq[0] = sw;
    i   = haddr[4:2];
    acc = hsel && hready && htrans[1];
    bad = i == 7 || (hwrite && (i == 3 || i == 4)) || hsize > 2 ||
          (int'(haddr[1:0]) % (1 << hsize)) != 0;
    eph = (acc && bad) ? 1 : (eph == 1) ? 2 : 0;
    if (hready) begin
      p_v = acc && !bad; p_w = hwrite; p_a = haddr[4:0]; p_s = hsize;
    end
  endtask

  initial begin
    mzero();
    forever begin
      exp_ready = eph != 1;
      exp_resp  = eph != 0;
      exp_rdata = (p_v && !p_w) ? rd(p_a[4:2]) : 32'd0;
      @(posedge clk or negedge reset_n);
      if (!reset_n) mzero();
      else mstep();
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("hreadyout", {31'd0, hreadyout}, {31'd0, exp_ready});
      chk("hresp", {31'd0, hresp}, {31'd0, exp_resp});
      chk("hrdata", hrdata, exp_rdata);
      chk("display", display_data, mem[0]);
      chk("ledr", {14'd0, ledr}, mem[1]);
      chk("ledg", {23'd0, ledg}, mem[2]);
    end
  end

  task automatic drive(input logic s, input logic [1:0] t, input logic w,
                       input logic [2:0] sz, input logic [27:0] a, input logic [31:0] d);
    hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a; hwdata = d;
    @(posedge clk);
    #1 hready = exp_ready;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 2'd0, 0, 3'd2, 28'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 0;
    hready = 1; hsel = 0; htrans = 0;
    @(negedge clk) reset_n = 1;
  endtask

  initial begin
    #1 reset_n = 0;
    #1;
    chk("rst_readyout", {31'd0, hreadyout}, 32'd1);
    chk("rst_resp", {31'd0, hresp}, 32'd0);
    chk("rst_rdata", hrdata, 32'd0);
    chk("rst_display", display_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    idle(3);
    // back-to-back word write then read
    drive(1, 2'd2, 1, 3'd2, 28'h00, 32'd0);
    drive(1, 2'd2, 0, 3'd2, 28'h00, 32'hDEADBEEF);
    chk("wr_display", display_data, 32'hDEADBEEF);
    chk("rd_display", hrdata, 32'hDEADBEEF);
    chk("rd_resp", {31'd0, hresp}, 32'd0);
    // byte lane write into scratch
    drive(1, 2'd2, 1, 3'd2, 28'h18, 32'd0);
    drive(1, 2'd2, 1, 3'd0, 28'h1A, 32'h11223344);
    drive(1, 2'd2, 0, 3'd2, 28'h18, 32'h00A50000);
    chk("byte_scratch", hrdata, 32'h11A53344);
    chk("byte_ledr", {14'd0, ledr}, 32'd0);
    chk("byte_ledg", {23'd0, ledg}, 32'd0);
    // write to read-only SW gives two-cycle error, then a normal read
    drive(1, 2'd2, 1, 3'd2, 28'h0C, 32'd0);
    chk("err1_ready", {31'd0, hreadyout}, 32'd0);
    chk("err1_resp", {31'd0, hresp}, 32'd1);
    drive(1, 2'd2, 0, 3'd2, 28'h0C, 32'hFFFFFFFF);
    chk("err2_ready", {31'd0, hreadyout}, 32'd1);
    chk("err2_resp", {31'd0, hresp}, 32'd1);
    drive(1, 2'd2, 0, 3'd2, 28'h0C, 32'hFFFFFFFF);
    chk("sw_read", hrdata, 32'h0002A5A5);
    chk("sw_resp", {31'd0, hresp}, 32'd0);
    // key[2] press and W1C clear
    key = 4'hB;
    idle(1);
    drive(1, 2'd2, 0, 3'd2, 28'h10, 32'd0);
    chk("key_press", hrdata, 32'h4B);
    drive(1, 2'd2, 1, 3'd2, 28'h14, 32'd0);
    drive(1, 2'd2, 0, 3'd2, 28'h10, 32'h4);
    chk("key_clr", hrdata, 32'h0B);
    key = 4'hF;
    idle(3);
    // set flag[1], then re-press on the same edge as its clear
    key = 4'hD; idle(3); key = 4'hF; idle(3);
    key = 4'hD;
    drive(1, 2'd2, 1, 3'd2, 28'h14, 32'd0);
    drive(1, 2'd2, 0, 3'd2, 28'h10, 32'h2);
    chk("set_wins", hrdata, 32'h2D);
    key = 4'hF; idle(3);
    drive(1, 2'd2, 1, 3'd2, 28'h14, 32'd0);
    drive(1, 2'd2, 0, 3'd2, 28'h10, 32'h2);
    chk("flag1_clr", hrdata, 32'h0F);
    // reset during ERR1
    drive(1, 2'd2, 1, 3'd2, 28'h1C, 32'd0);
    chk("err1c_ready", {31'd0, hreadyout}, 32'd0);
    #1 reset_n = 0;
    #1;
    chk("rstE_ready", {31'd0, hreadyout}, 32'd1);
    chk("rstE_resp", {31'd0, hresp}, 32'd0);
    chk("rstE_display", display_data, 32'd0);
    chk("rstE_rdata", hrdata, 32'd0);
    hready = 1; hsel = 0; htrans = 0;
    @(negedge clk) reset_n = 1;
    drive(1, 2'd2, 1, 3'd2, 28'h00, 32'd0);
    drive(1, 2'd2, 0, 3'd2, 28'h00, 32'h12345678);
    chk("post_rst_display", display_data, 32'h12345678);
    chk("post_rst_rdata", hrdata, 32'h12345678);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0]  sz;
      logic [27:0] a;
      if ($urandom_range(0, 49) == 0) sw = 18'($urandom);
      if ($urandom_range(0, 9) == 0) key = 4'($urandom);
      if ($urandom_range(0, 999) == 0) pulse_reset();
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = 28'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~2'((1 << sz) - 1);
      drive($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), sz, a, $urandom);
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
